uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Parametrised UART receiver for the game-controller datapath, replacing the fixed 8N1 receiver. It synchronises the serial line and decodes frames with configurable data width, parity and stop bits. It flags parity, framing and overrun errors. Good words go into a first-word-fall-through FIFO, so downstream logic (7-segment decode, command parser) can pop bytes at its own pace instead of catching a one-cycle valid strobe.

## Interface
Parameters:
- CYCLES_PER_BIT, 217, clock cycles per bit (25 MHz / 115200); legal range ≥ 4
- DATA_BITS, 8, data bits per frame; legal range 5–9
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even
- STOP_BITS, 1, stop bits per frame; 1 or 2
- FIFO_DEPTH, 4, FIFO entries; power of two, ≥ 2

Ports:
- i_CLK  in  1  single system clock; all logic on rising edge
- i_RESET  in  1  asynchronous, active-high reset
- i_SERIAL_DATA  in  1  raw RX line, asynchronous to i_CLK, idle high
- i_READ  in  1  pop FIFO head; ignored when empty
- o_DATA  out  DATA_BITS  FIFO head word; valid while o_DATA_VALID is high
- o_DATA_VALID  out  1  FIFO non-empty
- o_FIFO_COUNT  out  $clog2(FIFO_DEPTH)+1  current occupancy
- o_PARITY_ERR  out  1  one-cycle pulse: frame dropped, parity mismatch
- o_FRAME_ERR  out  1  one-cycle pulse: frame dropped, a stop bit sampled low
- o_OVERRUN  out  1  one-cycle pulse: good frame dropped, FIFO full

## Operation
- Input path: 2-flop synchroniser whose flops reset to 1, followed by one edge-detect register.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE: a synchronised falling edge goes to START and clears the bit timer.
- START: wait (CYCLES_PER_BIT-1)/2 cycles to reach mid-bit, then sample. Low goes to DATA. High is a glitch and returns to IDLE with no error.
- DATA: sample every CYCLES_PER_BIT cycles, LSB first, DATA_BITS samples. Then go to PARITY if PARITY≠0, else to STOP.
- PARITY: sample one bit. Odd mode requires XOR(data, parity bit) = 1; even mode requires 0.
- STOP: sample STOP_BITS bits, each one bit period apart.
- Frame end, at the mid-sample of the last stop bit:
  - Any stop sample low: pulse o_FRAME_ERR, drop the frame, go to WAIT_IDLE.
  - Parity bad (stops good): pulse o_PARITY_ERR, drop the frame, go to IDLE.
  - Frame good, FIFO not full (or full with i_READ high in the same cycle): push, go to IDLE.
  - Frame good, FIFO full, no i_READ: pulse o_OVERRUN, drop the frame, go to IDLE.
- Frame error and parity error in the same frame: only o_FRAME_ERR pulses.
- WAIT_IDLE: hold until the synchronised line is high, then go to IDLE. A break condition produces exactly one o_FRAME_ERR.
- FIFO:
  - Pop on i_READ && !empty.
  - Simultaneous push and pop: occupancy unchanged, order preserved.
  - Pointers wrap modulo FIFO_DEPTH.
  - o_FIFO_COUNT saturates naturally at FIFO_DEPTH.
- Reset (asynchronous, any time, including mid-frame):
  - FSM to IDLE, timers, pointers and count to 0.
  - All outputs 0; o_DATA 0.
  - Partial frame discarded, FIFO emptied.

## Timing
- Latency from line falling edge to first registered edge detect: 3 cycles.
- START mid-sample: (CYCLES_PER_BIT-1)/2 cycles after the edge detect.
- Each subsequent sample: exactly CYCLES_PER_BIT cycles after the previous one.
- Push occurs on the cycle after the last stop-bit mid-sample. o_DATA_VALID and o_DATA update on that same edge.
- Error pulses are asserted on that same edge and last exactly one cycle.
- The FSM returns to IDLE at mid stop bit, so back-to-back frames with zero idle time are received.
- o_DATA is first-word-fall-through: the head word is visible with no read latency. After a pop, the next head appears on the following edge.

## Structure
- Shared package uart_pkg:
  - Parity-mode constants (PAR_NONE, PAR_ODD, PAR_EVEN).
  - FSM state enum.
  - Default CYCLES_PER_BIT constant for 25 MHz / 115200.
- Sub-module sync_fifo (parameters WIDTH, DEPTH):
  - Register-array storage, count-based full/empty.
  - Reused by the future TX path.
- Top level contains the synchroniser, bit timer, FSM, shift register, parity check and the sync_fifo instance.

## Test plan
All scenarios use CYCLES_PER_BIT=16, DATA_BITS=8, PARITY=2, STOP_BITS=1, FIFO_DEPTH=4.
- Single frame 0xA5, correct even parity (0) -> o_DATA=0xA5, o_DATA_VALID=1, o_FIFO_COUNT=1, no error pulses; i_READ -> count 0.
- Parity bit forced wrong on 0x3C -> one o_PARITY_ERR pulse, FIFO count unchanged.
- Stop bit held low for 0x55, then line low 40 bit times -> exactly one o_FRAME_ERR; next good frame 0x12 received.
- Five back-to-back frames 0x01..0x05, no reads -> FIFO holds 0x01..0x04, one o_OVERRUN; pop four -> 0x01,0x02,0x03,0x04 in order.
- FIFO full, i_READ asserted on the push cycle of 0x77 -> no o_OVERRUN, count stays 4, 0x77 is last out.
- 4-cycle low glitch on idle line -> no push, no error pulse. i_RESET pulsed mid-DATA -> outputs 0, FIFO empty, next frame 0x9E decodes correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver FSM states and default bit timing.
package uart_pkg;

    // Parity modes selectable on the receiver (and later the transmitter)
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // 25 MHz system clock divided down to 115200 baud
    localparam int DEFAULT_CYCLES_PER_BIT = 217;

    // Receiver frame-decoding states
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small first-word-fall-through FIFO with register storage and count-based flags.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    // Storage needs no reset: the head is masked to zero while the FIFO is empty
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver: line synchroniser, frame decoder with error
// detection, and a FWFT FIFO so consumers can pop words at their own pace.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CYCLES_PER_BIT = DEFAULT_CYCLES_PER_BIT,
    parameter int DATA_BITS      = 8,
    parameter int PARITY         = PAR_NONE,
    parameter int STOP_BITS      = 1,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                          i_CLK,
    input  logic                          i_RESET,
    input  logic                          i_SERIAL_DATA,
    input  logic                          i_READ,
    output logic [DATA_BITS-1:0]          o_DATA,
    output logic                          o_DATA_VALID,
    output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_COUNT,
    output logic                          o_PARITY_ERR,
    output logic                          o_FRAME_ERR,
    output logic                          o_OVERRUN
);

    localparam int TW = $clog2(CYCLES_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CYCLES_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'((CYCLES_PER_BIT - 1) / 2 - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    rx_state_t state, state_next;

    logic                 sync_meta, sync_line, line_prev, line_fall;
    logic [TW-1:0]        timer;
    logic [BW-1:0]        bit_cnt;
    logic                 stop_cnt;
    logic                 stop_bad;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_bit;
    logic                 data_xor, parity_ok;
    logic                 half_tick, bit_tick;
    logic                 timer_clr, shift_en, par_en, stop_en;
    logic                 push, perr_set, ferr_set, ovr_set;
    logic                 fifo_empty, fifo_full;

    assign line_fall = line_prev & ~sync_line;
    assign half_tick = (timer == HALF_LAST);
    assign bit_tick  = (timer == BIT_LAST);
    assign data_xor  = (^shift_reg) ^ parity_bit;
    assign parity_ok = (PARITY == PAR_ODD)  ? data_xor  :
                       (PARITY == PAR_EVEN) ? ~data_xor : 1'b1;

    // Two-flop synchroniser idling high, plus a delayed copy for falling-edge detection
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            sync_meta <= 1'b1;
            sync_line <= 1'b1;
            line_prev <= 1'b1;
        end else begin
            sync_meta <= i_SERIAL_DATA;
            sync_line <= sync_meta;
            line_prev <= sync_line;
        end
    end

    // Bit timer restarts at every sample point so samples stay one bit period apart
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            timer <= '0;
        end else if (timer_clr) begin
            timer <= '0;
        end else begin
            timer <= timer + TW'(1);
        end
    end

    // FSM state register
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and per-sample strobes; frame verdict taken at the last stop mid-sample
    always_comb begin
        state_next = state;
        timer_clr  = 1'b0;
        shift_en   = 1'b0;
        par_en     = 1'b0;
        stop_en    = 1'b0;
        push       = 1'b0;
        perr_set   = 1'b0;
        ferr_set   = 1'b0;
        ovr_set    = 1'b0;
        case (state)
            S_IDLE: begin
                timer_clr = 1'b1;
                if (line_fall) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                if (half_tick) begin
                    timer_clr  = 1'b1;
                    state_next = sync_line ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (bit_tick) begin
                    timer_clr = 1'b1;
                    shift_en  = 1'b1;
                    if (bit_cnt == DATA_LAST) begin
                        state_next = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (bit_tick) begin
                    timer_clr  = 1'b1;
                    par_en     = 1'b1;
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_tick) begin
                    timer_clr = 1'b1;
                    stop_en   = 1'b1;
                    if (stop_cnt == STOP_LAST) begin
                        if (stop_bad || !sync_line) begin
                            ferr_set   = 1'b1;
                            state_next = S_WAIT_IDLE;
                        end else if (!parity_ok) begin
                            perr_set   = 1'b1;
                            state_next = S_IDLE;
                        end else if (fifo_full && !i_READ) begin
                            ovr_set    = 1'b1;
                            state_next = S_IDLE;
                        end else begin
                            push       = 1'b1;
                            state_next = S_IDLE;
                        end
                    end
                end
            end
            S_WAIT_IDLE: begin
                timer_clr = 1'b1;
                if (sync_line) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Frame datapath: LSB-first shift register, parity capture and stop-bit bookkeeping
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            stop_bad   <= 1'b0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
        end else begin
            if (state == S_START) begin
                bit_cnt  <= '0;
                stop_cnt <= 1'b0;
                stop_bad <= 1'b0;
            end
            if (shift_en) begin
                shift_reg <= {sync_line, shift_reg[DATA_BITS-1:1]};
                bit_cnt   <= bit_cnt + BW'(1);
            end
            if (par_en) begin
                parity_bit <= sync_line;
            end
            if (stop_en) begin
                stop_cnt <= stop_cnt + 1'b1;
                if (!sync_line) begin
                    stop_bad <= 1'b1;
                end
            end
        end
    end

    // Error pulses are registered so they line up with the push edge and last one cycle
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            o_PARITY_ERR <= 1'b0;
            o_FRAME_ERR  <= 1'b0;
            o_OVERRUN    <= 1'b0;
        end else begin
            o_PARITY_ERR <= perr_set;
            o_FRAME_ERR  <= ferr_set;
            o_OVERRUN    <= ovr_set;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (i_CLK),
        .rst       (i_RESET),
        .push      (push),
        .push_data (shift_reg),
        .pop       (i_READ),
        .head      (o_DATA),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (o_FIFO_COUNT)
    );

    assign o_DATA_VALID = ~fifo_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table, hand-written corner
// sequences and randomized frames checked against a queue-based model.
module tb_uart_rx_fifo;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       serial = 1'b1;
    logic       rd     = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic [2:0] count;
    logic       perr, ferr, ovr;

    int n_checks = 0;
    int n_pass   = 0;
    int perr_cnt = 0;
    int ferr_cnt = 0;
    int ovr_cnt  = 0;
    int base_p, base_f, base_o;
    int exp_p, exp_f, exp_o;
    int kind;
    logic [7:0] value;

    typedef struct {
        logic [7:0] value;
        bit         bad_parity;
        bit         bad_stop;
        int         exp_count;
        logic [7:0] exp_head;
        int         exp_perr;
        int         exp_ferr;
        int         exp_ovr;
    } vec_t;

    vec_t       vecs [8];
    logic [7:0] model_q [$];

    uart_rx_fifo #(
        .CYCLES_PER_BIT (CPB),
        .DATA_BITS      (8),
        .PARITY         (2),
        .STOP_BITS      (1),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .i_CLK         (clk),
        .i_RESET       (rst),
        .i_SERIAL_DATA (serial),
        .i_READ        (rd),
        .o_DATA        (data),
        .o_DATA_VALID  (valid),
        .o_FIFO_COUNT  (count),
        .o_PARITY_ERR  (perr),
        .o_FRAME_ERR   (ferr),
        .o_OVERRUN     (ovr)
    );

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    // Count high cycles of each error pulse so stuck or doubled pulses show up
    always @(negedge clk) begin
        if (perr) perr_cnt++;
        if (ferr) ferr_cnt++;
        if (ovr)  ovr_cnt++;
    end

    // Hard stop in case the stimulus ever stalls
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected summary");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Drive one 8E1 frame; break_bits extends a low stop bit into a line break
    task automatic applyStimulus(input logic [7:0] v, input bit bad_parity,
                                 input bit bad_stop, input int break_bits);
        @(negedge clk);
        serial = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            serial = v[i];
            repeat (CPB) @(negedge clk);
        end
        serial = (^v) ^ bad_parity;
        repeat (CPB) @(negedge clk);
        serial = ~bad_stop;
        repeat (CPB) @(negedge clk);
        if (bad_stop) repeat (break_bits * CPB) @(negedge clk);
        serial = 1'b1;
    endtask

    task automatic popCheck(input string name, input logic [7:0] expected);
        checkOutput({name, "_valid"}, valid, 1);
        checkOutput(name, data, expected);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic checkDeltas(input string name, input int p, input int f, input int o);
        checkOutput({name, "_perr"}, perr_cnt - base_p, p);
        checkOutput({name, "_ferr"}, ferr_cnt - base_f, f);
        checkOutput({name, "_ovr"},  ovr_cnt  - base_o, o);
    endtask

    task automatic snapBase();
        base_p = perr_cnt;
        base_f = ferr_cnt;
        base_o = ovr_cnt;
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1, 8'hA5, 0, 0, 0};
        vecs[1] = '{8'h3C, 1'b1, 1'b0, 1, 8'hA5, 1, 0, 0};
        vecs[2] = '{8'h01, 1'b0, 1'b0, 2, 8'hA5, 1, 0, 0};
        vecs[3] = '{8'h0F, 1'b0, 1'b1, 2, 8'hA5, 1, 1, 0};
        vecs[4] = '{8'h02, 1'b0, 1'b0, 3, 8'hA5, 1, 1, 0};
        vecs[5] = '{8'h03, 1'b0, 1'b0, 4, 8'hA5, 1, 1, 0};
        vecs[6] = '{8'h04, 1'b0, 1'b0, 4, 8'hA5, 1, 1, 1};
        vecs[7] = '{8'h05, 1'b0, 1'b0, 4, 8'hA5, 1, 1, 2};

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset_valid", valid, 0);
        checkOutput("reset_count", count, 0);
        checkOutput("reset_data", data, 0);
        checkOutput("reset_errs", {perr, ferr, ovr}, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Table-driven frames, no reads: fill, parity/frame errors, overruns
        snapBase();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].value, vecs[i].bad_parity, vecs[i].bad_stop, 0);
            repeat (4) @(negedge clk);
            checkOutput($sformatf("vec%0d_count", i), count, vecs[i].exp_count);
            checkOutput($sformatf("vec%0d_head", i), data, vecs[i].exp_head);
            checkDeltas($sformatf("vec%0d", i), vecs[i].exp_perr, vecs[i].exp_ferr, vecs[i].exp_ovr);
        end
        popCheck("tab_pop0", 8'hA5);
        popCheck("tab_pop1", 8'h01);
        popCheck("tab_pop2", 8'h02);
        popCheck("tab_pop3", 8'h03);
        checkOutput("tab_empty_count", count, 0);
        checkOutput("tab_empty_valid", valid, 0);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        checkOutput("pop_empty_count", count, 0);

        // Line break after a low stop bit gives exactly one frame error
        snapBase();
        applyStimulus(8'h55, 1'b0, 1'b1, 40);
        repeat (2 * CPB) @(negedge clk);
        checkDeltas("break", 0, 1, 0);
        checkOutput("break_count", count, 0);
        applyStimulus(8'h12, 1'b0, 1'b0, 0);
        repeat (4) @(negedge clk);
        checkOutput("after_break_count", count, 1);
        popCheck("after_break_head", 8'h12);

        // Full FIFO with a read landing exactly on the push cycle
        for (int i = 0; i < 4; i++) applyStimulus(8'h21 + 8'(i), 1'b0, 1'b0, 0);
        checkOutput("fill_count", count, 4);
        snapBase();
        fork
            applyStimulus(8'h77, 1'b0, 1'b0, 0);
            begin
                @(negedge clk);
                repeat (169) @(negedge clk);
                rd = 1'b1;
                @(negedge clk);
                rd = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        checkDeltas("rdpush", 0, 0, 0);
        checkOutput("rdpush_count", count, 4);
        popCheck("rdpush_pop0", 8'h22);
        popCheck("rdpush_pop1", 8'h23);
        popCheck("rdpush_pop2", 8'h24);
        popCheck("rdpush_pop3", 8'h77);

        // Short low glitch on the idle line is ignored
        snapBase();
        @(negedge clk);
        serial = 1'b0;
        repeat (4) @(negedge clk);
        serial = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        checkOutput("glitch_count", count, 0);
        checkDeltas("glitch", 0, 0, 0);

        // Asynchronous reset mid-data empties the FIFO and discards the partial frame
        applyStimulus(8'h33, 1'b0, 1'b0, 0);
        checkOutput("prereset_count", count, 1);
        @(negedge clk);
        serial = 1'b0;
        repeat (CPB) @(negedge clk);
        serial = 1'b0;
        repeat (CPB) @(negedge clk);
        serial = 1'b1;
        repeat (CPB) @(negedge clk);
        #3 rst = 1'b1;
        @(negedge clk);
        checkOutput("midreset_valid", valid, 0);
        checkOutput("midreset_count", count, 0);
        checkOutput("midreset_data", data, 0);
        serial = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        snapBase();
        repeat (12 * CPB) @(negedge clk);
        checkOutput("postreset_count", count, 0);
        applyStimulus(8'h9E, 1'b0, 1'b0, 0);
        repeat (4) @(negedge clk);
        checkOutput("postreset_frame_count", count, 1);
        checkDeltas("postreset", 0, 0, 0);
        popCheck("postreset_head", 8'h9E);

        // Randomized frames against a queue model of the FIFO and error counters
        snapBase();
        exp_p = 0;
        exp_f = 0;
        exp_o = 0;
        for (int it = 0; it < 40; it++) begin
            if (model_q.size() > 0 && $urandom_range(0, 2) == 0) begin
                popCheck("rand_pop", model_q.pop_front());
            end
            kind  = int'($urandom_range(0, 9));
            value = 8'($urandom);
            if (kind <= 5) begin
                applyStimulus(value, 1'b0, 1'b0, 0);
                if (model_q.size() < DEPTH) model_q.push_back(value);
                else exp_o++;
            end else if (kind <= 7) begin
                applyStimulus(value, 1'b1, 1'b0, 0);
                exp_p++;
            end else begin
                applyStimulus(value, (kind == 9), 1'b1, 0);
                exp_f++;
            end
            repeat ($urandom_range(0, 8)) @(negedge clk);
            checkOutput("rand_count", count, model_q.size());
        end
        repeat (4) @(negedge clk);
        checkDeltas("rand", exp_p, exp_f, exp_o);
        while (model_q.size() > 0) popCheck("rand_drain", model_q.pop_front());
        checkOutput("rand_final_count", count, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
